// File: rtl/serial_adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : serial_adder_pkg                                          |
// | Purpose  : Shared nibble width and controller state encoding.        |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fourBitAdder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fourBitAdder                                              |
// | Purpose  : 4-bit ripple-carry adder built from full-adder cells.     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module fourBitAdder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout = w_c[4];

endmodule
`default_nettype wire

// File: rtl/serial_nibble_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : serial_nibble_adder                                       |
// | Purpose  : Wide add/subtract done one nibble per clock, LSB first.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module serial_nibble_adder
  import serial_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                        cin,
  input  logic                        sub,
  output logic                        busy,
  output logic                        done,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                        cout,
  output logic                        ovf
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);

  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NIBBLES - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [IDX_W-1:0]   r_idx;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic               r_carry;
  logic [W-1:0]       r_acc;

  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_b_nib;
  logic [NIBBLE_W-1:0] w_nib_sum;
  logic                w_nib_cout;
  logic [W-1:0]        w_acc_next;
  logic                w_last;

  fourBitAdder u_nibble_adder (
    .a    (w_a_nib),
    .b    (w_b_nib),
    .cin  (r_carry),
    .sum  (w_nib_sum),
    .cout (w_nib_cout)
  );

  always_comb begin
    w_state_next = r_state;
    w_a_nib      = r_a[r_idx*NIBBLE_W +: NIBBLE_W];
    w_b_nib      = r_b[r_idx*NIBBLE_W +: NIBBLE_W];
    w_last       = (r_idx == c_last_idx);
    // Accumulator with the current slice merged in, so the final edge can
    // publish the complete result without waiting one more cycle.
    w_acc_next   = r_acc;
    w_acc_next[r_idx*NIBBLE_W +: NIBBLE_W] = w_nib_sum;

    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_acc   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_acc   <= w_acc_next;
          r_carry <= w_nib_cout;
          r_idx   <= r_idx + IDX_W'(1);
          if (w_last) begin
            sum  <= w_acc_next;
            cout <= w_nib_cout;
            ovf  <= (r_a[W-1] == r_b[W-1]) && (w_acc_next[W-1] != r_a[W-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_serial_nibble_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_serial_nibble_adder                                    |
// | Purpose  : Directed self-checking bench for serial_nibble_adder.     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_serial_nibble_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int          n_compared   = 0;
  int          n_mismatched = 0;
  logic [15:0] prev_sum     = 16'h0000;

  serial_nibble_adder #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " sum"},  sum,  0);
    check({tag, " cout"}, cout, 0);
    check({tag, " ovf"},  ovf,  0);
  endtask

  // One full operation: accept, expect done exactly 4 edges later.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, input logic sb, input logic [15:0] es,
                        input logic ec, input logic eo);
    int lat;
    a = av; b = bv; cin = ci; sub = sb; start = 1'b1;
    tick();
    start = 1'b0;
    a = ~av; b = ~bv; cin = ~ci; sub = ~sb;
    check({tag, " busy@E0"}, busy, 1);
    check({tag, " done@E0"}, done, 0);
    lat = 0;
    while (!done && lat < 10) begin
      tick();
      lat++;
      if (!done) begin
        check({tag, " hold sum"}, sum, prev_sum);
        check({tag, " busy run"}, busy, 1);
      end
    end
    check({tag, " latency"}, lat, 4);
    check({tag, " sum"},  sum,  es);
    check({tag, " cout"}, cout, ec);
    check({tag, " ovf"},  ovf,  eo);
    tick();
    check({tag, " done fall"}, done, 0);
    check({tag, " busy fall"}, busy, 0);
    prev_sum = es;
  endtask

  initial begin
    int n_done;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    tick();
    tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    run_op("add simple",  16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("add ripple",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add cin ovf", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub neg",     16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub ovf",     16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // start pulsed mid-operation must not disturb the latched operands
    a = 16'h0001; b = 16'h0001; cin = 1'b0; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 16'hAAAA; start = 1'b1;
    tick();
    start = 1'b0;
    check("busy-start E2 sum", sum, prev_sum);
    tick();
    check("busy-start E3 sum", sum, prev_sum);
    check("busy-start E3 done", done, 0);
    tick();
    check("busy-start E4 done", done, 1);
    check("busy-start E4 sum", sum, 16'h0002);
    n_done = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) n_done++;
    end
    check("busy-start done count", n_done, 1);
    check("busy-start idle", busy, 0);

    rst = 1'b1; start = 1'b1; a = 16'h0005; b = 16'h0005;
    tick();
    check("rst beats start busy", busy, 0);
    check("rst beats start sum", sum, 0);
    rst = 1'b0; start = 1'b0;
    tick();
    check("rst beats start idle", busy, 0);
    prev_sum = 16'h0000;

    // reset in the middle of RUN discards the operation
    run_op("pre-abort", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0);
    a = 16'h0F0F; b = 16'h0101; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_zero("abort E3");
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) n_done++;
    end
    check("abort no done", n_done, 0);
    prev_sum = 16'h0000;
    run_op("after abort", 16'h0100, 16'h0200, 1'b0, 1'b0, 16'h0300, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
`default_nettype wire
